// File: rtl/fp_stream_accumulator_if.sv
// Handshake and adder-port bundle for fp_stream_accumulator.
// The slave side is the accumulator; the master side is the stream source, sum consumer and adder.
interface fp_stream_accumulator_if #(
    parameter int COUNT_W = 8
);
    logic               start;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_data;
    logic               in_last;
    logic [31:0]        add_a;
    logic [31:0]        add_b;
    logic [31:0]        add_result;
    logic               sum_valid;
    logic               sum_ready;
    logic [31:0]        sum_data;
    logic [COUNT_W-1:0] sum_count;
    logic               busy;

    modport slave (
        input  start, in_valid, in_data, in_last, add_result, sum_ready,
        output in_ready, add_a, add_b, sum_valid, sum_data, sum_count, busy
    );

    modport master (
        output start, in_valid, in_data, in_last, add_result, sum_ready,
        input  in_ready, add_a, add_b, sum_valid, sum_data, sum_count, busy
    );
endinterface

// File: rtl/fp_stream_accumulator.sv
// Sequential wrapper around an external combinational float adder: accumulates a stream of
// IEEE-754 singles, bypassing the adder for zero operands, a zero running sum and exact cancellation.
module fp_stream_accumulator #(
    parameter int COUNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fp_stream_accumulator_if.slave io
);
    typedef enum logic [1:0] {S_IDLE, S_ACC, S_ADD, S_DONE} state_e;

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    state_e             state_q;
    logic [31:0]        acc_q, acc_d, b_q;
    logic [COUNT_W-1:0] cnt_q;
    logic               last_q, in_ready_q, sum_valid_q, busy_q;

    // The adder is only trusted for two nonzero operands that do not cancel exactly.
    always_comb begin
        acc_d = io.add_result;
        if (b_q[30:23] == 8'd0)
            acc_d = acc_q;
        else if (acc_q[30:23] == 8'd0)
            acc_d = b_q;
        else if (acc_q[30:0] == b_q[30:0] && acc_q[31] != b_q[31])
            acc_d = 32'h0000_0000;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= 32'h0;
            b_q         <= 32'h0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            sum_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (io.start) begin
                        acc_q      <= 32'h0;
                        cnt_q      <= '0;
                        last_q     <= 1'b0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (io.in_valid) begin
                        b_q        <= io.in_data;
                        last_q     <= io.in_last;
                        cnt_q      <= (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                        in_ready_q <= 1'b0;
                        state_q    <= S_ADD;
                    end
                end
                S_ADD: begin
                    acc_q <= acc_d;
                    if (last_q) begin
                        sum_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= S_ACC;
                    end
                end
                S_DONE: begin
                    if (io.sum_ready) begin
                        sum_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // acc is only rewritten on start or in ADD, so the sum holds from DONE until the next start.
    assign io.in_ready  = in_ready_q;
    assign io.add_a     = acc_q;
    assign io.add_b     = b_q;
    assign io.sum_valid = sum_valid_q;
    assign io.sum_data  = acc_q;
    assign io.sum_count = cnt_q;
    assign io.busy      = busy_q;
endmodule

// File: tb/tb_fp_stream_accumulator.sv
// Scoreboard bench for fp_stream_accumulator with a behavioural adder that is only valid
// for nonzero, non-cancelling operands.
module tb_fp_stream_accumulator;
    localparam int COUNT_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_err = 0;
    int   n_chk = 0;

    logic [31:0]        exp_data_q[$];
    logic [COUNT_W-1:0] exp_cnt_q[$];

    fp_stream_accumulator_if #(.COUNT_W(COUNT_W)) io ();

    fp_stream_accumulator #(.COUNT_W(COUNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    always #5 clk = ~clk;

    function automatic real f2r(logic [31:0] f);
        logic [10:0] e;
        if (f[30:23] == 8'd0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'b0});
    endfunction

    function automatic logic [31:0] r2f(real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Garbage on the cases the real adder cannot handle, so a missing bypass shows up.
    always_comb begin
        if (io.add_a[30:23] == 8'd0 || io.add_b[30:23] == 8'd0 ||
            (io.add_a[30:0] == io.add_b[30:0] && io.add_a[31] != io.add_b[31]))
            io.add_result = 32'hDEAD_BEEF;
        else
            io.add_result = r2f(f2r(io.add_a) + f2r(io.add_b));
    end

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: a sum handshake happens at the posedge following this sample.
    always @(negedge clk) begin
        if (rst_n && io.sum_valid && io.sum_ready) begin
            chk("sb_pending", 64'(exp_data_q.size() != 0), 64'd1);
            if (exp_data_q.size() != 0) begin
                chk("sum_data", 64'(io.sum_data), 64'(exp_data_q.pop_front()));
                chk("sum_count", 64'(io.sum_count), 64'(exp_cnt_q.pop_front()));
            end
        end
    end

    task automatic start_acc();
        io.start = 1'b1;
        @(posedge clk); #1;
        io.start = 1'b0;
    endtask

    task automatic send(logic [31:0] d, logic last);
        int t = 0;
        while (!io.in_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (t == 20) chk("rdy_timeout", 64'(io.in_ready), 64'd1);
        io.in_valid = 1'b1;
        io.in_data  = d;
        io.in_last  = last;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        io.in_last  = 1'b0;
        chk("rdy_in_add", 64'(io.in_ready), 64'd0);
    endtask

    task automatic wait_done();
        int t = 0;
        while (exp_data_q.size() != 0 && t < 60) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain", 64'(exp_data_q.size()), 64'd0);
    endtask

    task automatic expect_sum(logic [31:0] d, logic [COUNT_W-1:0] c);
        exp_data_q.push_back(d);
        exp_cnt_q.push_back(c);
    endtask

    logic [31:0] held;

    initial begin
        io.start = 1'b0; io.in_valid = 1'b0; io.in_data = 32'h0; io.in_last = 1'b0;
        io.sum_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(io.in_ready), 64'd0);
        chk("rst_sum_valid", 64'(io.sum_valid), 64'd0);
        chk("rst_busy", 64'(io.busy), 64'd0);
        chk("rst_add_a", 64'(io.add_a), 64'd0);
        chk("rst_add_b", 64'(io.add_b), 64'd0);
        chk("rst_sum_count", 64'(io.sum_count), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1.0 + 2.0
        expect_sum(32'h4040_0000, 8'd2);
        start_acc();
        chk("busy_run", 64'(io.busy), 64'd1);
        send(32'h3F80_0000, 1'b0);
        send(32'h4000_0000, 1'b1);
        wait_done();
        chk("idle_busy", 64'(io.busy), 64'd0);

        // single operand, zero-acc bypass, latency
        expect_sum(32'hC0A0_0000, 8'd1);
        start_acc();
        send(32'hC0A0_0000, 1'b1);
        chk("lat_edge1", 64'(io.sum_valid), 64'd0);
        @(posedge clk); #1;
        chk("lat_edge2", 64'(io.sum_valid), 64'd1);
        wait_done();

        // exact cancellation then bypass
        expect_sum(32'h3F00_0000, 8'd3);
        start_acc();
        send(32'h3FC0_0000, 1'b0);
        send(32'hBFC0_0000, 1'b0);
        send(32'h3F00_0000, 1'b1);
        wait_done();

        // zero operand skipped
        expect_sum(32'h4040_0000, 8'd3);
        start_acc();
        send(32'h4000_0000, 1'b0);
        chk("rdy_back", 64'(io.in_ready), 64'd0);
        @(posedge clk); #1;
        chk("rdy_acc", 64'(io.in_ready), 64'd1);
        send(32'h0000_0000, 1'b0);
        send(32'h3F80_0000, 1'b1);
        wait_done();

        // consumer back-pressure, start ignored in DONE
        io.sum_ready = 1'b0;
        expect_sum(32'h4040_0000, 8'd2);
        start_acc();
        send(32'h3F80_0000, 1'b0);
        send(32'h4000_0000, 1'b1);
        @(posedge clk); #1;
        held = io.sum_data;
        for (int i = 0; i < 5; i++) begin
            io.start = (i == 2);
            @(posedge clk); #1;
            chk("hold_valid", 64'(io.sum_valid), 64'd1);
            chk("hold_data", 64'(io.sum_data), 64'(held));
            chk("hold_count", 64'(io.sum_count), 64'd2);
        end
        io.start = 1'b0;
        io.sum_ready = 1'b1;
        wait_done();
        chk("post_busy", 64'(io.busy), 64'd0);
        chk("post_valid", 64'(io.sum_valid), 64'd0);
        chk("post_data", 64'(io.sum_data), 64'h4040_0000);
        @(posedge clk); #1;
        chk("no_restart", 64'(io.busy), 64'd0);

        // reset while in ADD
        start_acc();
        send(32'h4000_0000, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("radd_in_ready", 64'(io.in_ready), 64'd0);
        chk("radd_sum_valid", 64'(io.sum_valid), 64'd0);
        chk("radd_add_a", 64'(io.add_a), 64'd0);
        chk("radd_add_b", 64'(io.add_b), 64'd0);
        chk("radd_count", 64'(io.sum_count), 64'd0);
        chk("radd_busy", 64'(io.busy), 64'd0);
        expect_sum(32'h4040_0000, 8'd2);
        start_acc();
        send(32'h3F80_0000, 1'b0);
        send(32'h4000_0000, 1'b1);
        wait_done();

        // small-integer random streams, reference is the exact integer sum
        for (int s = 0; s < 3; s++) begin
            int n;
            int acc;
            int v;
            n = $urandom_range(6, 2);
            acc = 0;
            start_acc();
            for (int k = 0; k < n; k++) begin
                v = int'($urandom_range(8, 0)) - 4;
                acc += v;
                if (k == n - 1) expect_sum(r2f(real'(acc)), COUNT_W'(n));
                send(r2f(real'(v)), k == n - 1);
            end
            wait_done();
        end

        // count saturation: 260 x 1.0
        expect_sum(r2f(260.0), 8'd255);
        start_acc();
        for (int k = 0; k < 260; k++) send(32'h3F80_0000, k == 259);
        wait_done();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
